// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_BITS = 5
);
  logic i_start;
  logic [7:0] i_rx_data;
  logic i_rx_valid;
  logic o_write_enable;
  logic [ADDR_BITS-1:0] o_write_addr;
  logic [WORD_WIDTH-1:0] o_data;
  logic o_loading;
  logic o_done;
  logic [ADDR_BITS:0] o_word_count;
  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input o_write_enable, o_write_addr, o_data, o_loading, o_done, o_word_count
  );
  modport slave (
    input i_start, i_rx_data, i_rx_valid,
    output o_write_enable, o_write_addr, o_data, o_loading, o_done, o_word_count
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: assembles an MSB-first byte stream into words and writes them to instruction memory.
module program_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_BITS = 5,
  parameter logic [WORD_WIDTH-1:0] HALT_WORD = '1
) (
  input logic i_clock,
  input logic i_reset,
  program_loader_if.slave bus
);
  localparam int BYTES = WORD_WIDTH / 8;
  localparam int CW = BYTES > 1 ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(BYTES - 1);
  localparam logic [CW-1:0] C_ONE = 1;
  localparam logic [ADDR_BITS-1:0] A_ONE = 1;
  localparam logic [ADDR_BITS-1:0] A_LAST = '1;
  localparam logic [ADDR_BITS:0] WC_ONE = 1;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WORD_WIDTH-1:0] shift, shift_n, data, data_n, word;
  logic [ADDR_BITS-1:0] addr, addr_n, waddr, waddr_n;
  logic [ADDR_BITS:0] wc, wc_n;
  logic we, we_n, loading, loading_n, done, done_n;
  logic accept, complete;
  assign accept = state == LOAD && bus.i_rx_valid && !bus.i_start;
  assign word = (shift << 8) | WORD_WIDTH'(bus.i_rx_data);
  assign complete = accept && cnt == C_LAST;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      cnt <= '0;
      shift <= '0;
      addr <= '0;
      wc <= '0;
      we <= 1'b0;
      data <= '0;
      waddr <= '0;
      loading <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shift <= shift_n;
      addr <= addr_n;
      wc <= wc_n;
      we <= we_n;
      data <= data_n;
      waddr <= waddr_n;
      loading <= loading_n;
      done <= done_n;
    end
  end
  // A start pulse restarts from any state; the last word or a halt word ends the load.
  always_comb begin
    state_n = state;
    if (bus.i_start) state_n = LOAD;
    else if (complete && (word == HALT_WORD || addr == A_LAST)) state_n = DONE;
  end
  always_comb begin
    cnt_n = bus.i_start ? '0 : complete ? '0 : accept ? cnt + C_ONE : cnt;
    shift_n = bus.i_start ? '0 : accept ? word : shift;
    addr_n = bus.i_start ? '0 : (complete && addr != A_LAST) ? addr + A_ONE : addr;
    wc_n = bus.i_start ? '0 : complete ? wc + WC_ONE : wc;
    we_n = complete;
    data_n = complete ? word : data;
    waddr_n = complete ? addr : waddr;
    loading_n = state_n == LOAD;
    done_n = state_n == DONE;
  end
  assign bus.o_write_enable = we;
  assign bus.o_write_addr = waddr;
  assign bus.o_data = data;
  assign bus.o_word_count = wc;
  assign bus.o_loading = loading;
  assign bus.o_done = done;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table vectors, directed corner sequences and randomized traffic against a queue-based model.
module tb_program_loader;
  localparam int W = 32;
  localparam int A = 5;
  logic i_clock = 1'b0;
  logic i_reset = 1'b0;
  program_loader_if #(.WORD_WIDTH(W), .ADDR_BITS(A)) bus ();
  program_loader #(.WORD_WIDTH(W), .ADDR_BITS(A)) dut (.i_clock(i_clock), .i_reset(i_reset), .bus(bus));
  always #5 i_clock = ~i_clock;
  int checks = 0;
  int errors = 0;
  bit m_load, m_done, m_we;
  logic [W-1:0] m_data;
  int m_addr, m_waddr, m_cnt;
  logic [7:0] pend[$];
  typedef struct {
    bit s;
    bit v;
    logic [7:0] b;
    bit we;
    logic [W-1:0] d;
    int a;
    int cnt;
    bit ld;
    bit dn;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_load = 0; m_done = 0; m_we = 0; m_data = '0;
    m_addr = 0; m_waddr = 0; m_cnt = 0; pend.delete();
  endtask
  task automatic model_step(input bit s, input bit v, input logic [7:0] b);
    m_we = 0;
    if (s) begin
      m_load = 1; m_done = 0; pend.delete(); m_addr = 0; m_cnt = 0;
    end else if (m_load && v) begin
      pend.push_back(b);
      if (pend.size() == W / 8) begin
        m_data = '0;
        foreach (pend[k]) m_data = (m_data << 8) | W'(pend[k]);
        pend.delete();
        m_we = 1; m_waddr = m_addr; m_cnt++;
        if (m_data == {W{1'b1}} || m_addr == 2 ** A - 1) begin
          m_load = 0; m_done = 1;
        end else m_addr++;
      end
    end
  endtask
  task automatic cmp_model();
    chk("we", bus.o_write_enable, m_we);
    chk("data", bus.o_data, m_data);
    chk("waddr", bus.o_write_addr, m_waddr);
    chk("count", bus.o_word_count, m_cnt);
    chk("loading", bus.o_loading, m_load);
    chk("done", bus.o_done, m_done);
    chk("excl", bus.o_loading & bus.o_done, 0);
  endtask
  task automatic cyc(input bit s, input bit v, input logic [7:0] b);
    bus.i_start = s; bus.i_rx_valid = v; bus.i_rx_data = b;
    @(posedge i_clock);
    model_step(s, v, b);
    #1 cmp_model();
  endtask
  task automatic do_reset();
    i_reset = 1'b0;
    model_reset();
    #1 cmp_model();
    @(posedge i_clock);
    #1 cmp_model();
    i_reset = 1'b1;
  endtask
  task automatic send_word(input logic [W-1:0] w);
    for (int k = W / 8 - 1; k >= 0; k--) cyc(0, 1, w[k*8 +: 8]);
  endtask
  initial begin
    bus.i_start = 0; bus.i_rx_valid = 0; bus.i_rx_data = '0;
    model_reset();
    #1 cmp_model();
    @(posedge i_clock);
    #1 i_reset = 1'b1;
    vecs[0] = '{1, 1, 8'hEE, 0, 32'h0, 0, 0, 1, 0};
    vecs[1] = '{0, 1, 8'h12, 0, 32'h0, 0, 0, 1, 0};
    vecs[2] = '{0, 1, 8'h34, 0, 32'h0, 0, 0, 1, 0};
    vecs[3] = '{0, 1, 8'h56, 0, 32'h0, 0, 0, 1, 0};
    vecs[4] = '{0, 1, 8'h78, 1, 32'h12345678, 0, 1, 1, 0};
    vecs[5] = '{0, 0, 8'h00, 0, 32'h12345678, 0, 1, 1, 0};
    vecs[6] = '{0, 1, 8'h9A, 0, 32'h12345678, 0, 1, 1, 0};
    foreach (vecs[i]) begin
      bus.i_start = vecs[i].s; bus.i_rx_valid = vecs[i].v; bus.i_rx_data = vecs[i].b;
      @(posedge i_clock);
      model_step(vecs[i].s, vecs[i].v, vecs[i].b);
      #1;
      chk("t_we", bus.o_write_enable, vecs[i].we);
      chk("t_data", bus.o_data, vecs[i].d);
      chk("t_addr", bus.o_write_addr, vecs[i].a);
      chk("t_cnt", bus.o_word_count, vecs[i].cnt);
      chk("t_ld", bus.o_loading, vecs[i].ld);
      chk("t_dn", bus.o_done, vecs[i].dn);
    end
    cyc(1, 0, 8'h00);
    for (int i = 0; i < 3; i++) send_word(32'h1000_0000 + i);
    send_word(32'hFFFF_FFFF);
    chk("halt_data", bus.o_data, 32'hFFFF_FFFF);
    chk("halt_addr", bus.o_write_addr, 3);
    chk("halt_done", bus.o_done, 1);
    chk("halt_cnt", bus.o_word_count, 4);
    for (int i = 0; i < 8; i++) cyc(0, 1, 8'($urandom));
    cyc(1, 0, 8'h00);
    for (int i = 0; i < 32; i++) send_word({8'($urandom_range(0, 254)), 24'($urandom)});
    chk("full_addr", bus.o_write_addr, 31);
    chk("full_we", bus.o_write_enable, 1);
    chk("full_done", bus.o_done, 1);
    chk("full_cnt", bus.o_word_count, 32);
    send_word(32'h0123_4567);
    chk("full_hold", bus.o_word_count, 32);
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h01);
    cyc(0, 1, 8'h02);
    cyc(1, 1, 8'h03);
    send_word(32'hAABB_CCDD);
    chk("rs_we", bus.o_write_enable, 1);
    chk("rs_data", bus.o_data, 32'hAABB_CCDD);
    chk("rs_addr", bus.o_write_addr, 0);
    chk("rs_cnt", bus.o_word_count, 1);
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'h55);
    cyc(1, 1, 8'h66);
    send_word(32'hCAFE_F00D);
    chk("idle_data", bus.o_data, 32'hCAFE_F00D);
    chk("idle_cnt", bus.o_word_count, 1);
    cyc(0, 1, 8'h11);
    cyc(0, 1, 8'h22);
    cyc(0, 1, 8'h33);
    i_reset = 1'b0;
    #1;
    chk("ar_data", bus.o_data, 0);
    chk("ar_ld", bus.o_loading, 0);
    chk("ar_cnt", bus.o_word_count, 0);
    model_reset();
    @(posedge i_clock);
    #1 i_reset = 1'b1;
    cyc(0, 1, 8'h44);
    chk("ar_we", bus.o_write_enable, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0 ? 8'hFF : 8'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 32: instruction word width in bits; SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_BITS, default 5: width of the instruction memory write address.
REQ-003 The block SHALL have parameter HALT_WORD, default all ones of WORD_WIDTH: end-of-program marker word.
REQ-004 The block SHALL have port i_clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_start, input, 1 bit: one-cycle pulse that begins or restarts a program load.
REQ-007 The block SHALL have port i_rx_data, input, 8 bits: received byte.
REQ-008 The block SHALL have port i_rx_valid, input, 1 bit: i_rx_data is valid this cycle, one byte per asserted cycle.
REQ-009 The block SHALL have port o_write_enable, output, 1 bit: write strobe to the instruction memory write port.
REQ-010 The block SHALL have port o_write_addr, output, ADDR_BITS bits: instruction memory write address.
REQ-011 The block SHALL have port o_data, output, WORD_WIDTH bits: assembled word to be written.
REQ-012 The block SHALL have port o_loading, output, 1 bit: high while in state LOAD.
REQ-013 The block SHALL have port o_done, output, 1 bit: high while in state DONE.
REQ-014 The block SHALL have port o_word_count, output, ADDR_BITS+1 bits: number of words written since the last start.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, LOAD and DONE, and SHALL be a registered state machine.
REQ-016 In IDLE: i_start=1 SHALL go to LOAD and clear the byte counter, the shift register, the address and o_word_count; i_rx_valid SHALL be ignored, including in the cycle of i_start.
REQ-017 In LOAD: each cycle with i_rx_valid=1 SHALL accept one byte, MSB-first (first byte lands in o_data[WORD_WIDTH-1 -: 8]), by shifting left by 8 and inserting i_rx_data at the LSBs.
REQ-018 The byte counter SHALL count modulo WORD_WIDTH/8 and SHALL wrap to 0 on each completed word.
REQ-019 When the byte accepted completes a word, on that same edge the block SHALL register o_data=assembled word, o_write_addr=current address and o_write_enable=1, so the strobe is high for exactly the next cycle (latency 1 clock after the last byte).
REQ-020 o_write_enable SHALL be 0 in every other cycle; o_data and o_write_addr SHALL hold their last values while the strobe is low.
REQ-021 After each write, the address SHALL increment by 1 and o_word_count SHALL increment by 1.
REQ-022 A completed word equal to HALT_WORD SHALL be written like any other word, and the FSM SHALL then go to DONE.
REQ-023 A write to address 2^ADDR_BITS-1 SHALL make the FSM go to DONE; the address SHALL NOT wrap to 0 within one load.
REQ-024 i_start=1 in LOAD SHALL restart the load: counters, address and o_word_count cleared, partial word discarded, no write issued that cycle, remain in LOAD; i_rx_valid in the same cycle SHALL be ignored.
REQ-025 In DONE: i_rx_valid SHALL be ignored; o_done=1; o_word_count SHALL hold; i_start=1 SHALL go to LOAD with the same clearing as REQ-016.
REQ-026 o_loading and o_done SHALL be registered decodes of the state and SHALL never both be 1.

Reset
REQ-027 i_reset=0 SHALL immediately, without waiting for a clock, force state IDLE, o_write_enable=0, o_write_addr=0, o_data=0, o_word_count=0, o_loading=0, o_done=0, and clear the byte counter and shift register.
REQ-028 Reset asserted mid-word or mid-load SHALL discard all partial data; no write strobe SHALL occur in or after the reset cycle until a new word completes.
REQ-029 After reset is released, the block SHALL need i_start before accepting any byte.

Verification
REQ-030 Scenario: reset, i_start, then bytes 0x12,0x34,0x56,0x78 -> one strobe with o_data=0x12345678 and o_write_addr=0 one cycle after the 4th byte; o_word_count=1; o_loading=1.
REQ-031 Scenario: three words, then 0xFF x4 -> writes at addresses 0..3 with the 4th equal to 0xFFFFFFFF; o_done=1 next cycle; o_word_count=4; further bytes cause no strobe.
REQ-032 Scenario: 32 non-halt words (ADDR_BITS=5) -> last strobe at address 31; DONE; o_word_count=32; a 33rd word is ignored.
REQ-033 Scenario: 2 bytes, then i_start, then 0xAA,0xBB,0xCC,0xDD -> single strobe with o_data=0xAABBCCDD at address 0.
REQ-034 Scenario: bytes sent in IDLE and together with the i_start pulse -> no strobe; the word assembles only from bytes sent after the start cycle.
REQ-035 Scenario: i_reset pulsed low between the 3rd and 4th byte -> outputs zero asynchronously; the 4th byte is ignored (IDLE); no strobe.
